pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder; next generation of the team's fixed 4-bit combinational adder.
- Splits a WIDTH-bit add into CHUNK-bit slices, one slice per pipeline stage, with carry registered between stages.
- Throughput is one add per cycle; a valid/ready handshake on both sides provides backpressure.
- Sits between operand sources and datapath consumers (ALU/accumulator) where one full-width ripple is too long for the clock period.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per stage; the number of stages is STAGES = WIDTH/CHUNK (derived, not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  operand A (unsigned).
- in_b  input  WIDTH  operand B (unsigned).
- in_cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  sum, low WIDTH bits of a+b+cin.
- out_cout  output  1  carry-out of the MSB.

Behaviour:
- Reset: all per-stage valid bits, out_valid, out_sum and out_cout clear to 0 asynchronously; in_ready is 1 after reset.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall. Global stall: when stall=1, no pipeline register changes.
- Accept: when in_valid & in_ready, the transfer is taken; when in_valid=0 and no stall, a bubble (valid=0) enters.
- Stage 0 computes the lowest CHUNK-bit slice: a[CHUNK-1:0]+b[CHUNK-1:0]+cin. It registers that sum slice, the slice carry, and the upper operand bits.
- Stage k (1..STAGES-1) adds slice k of the delayed operands plus the registered carry from stage k-1. It forwards the already-finished lower sum slices.
- Final stage register drives out_sum, out_cout and out_valid directly; no combinational path from inputs to outputs.
- Latency: an accepted operand set appears on out_valid exactly STAGES cycles later when unstalled. Each stalled cycle adds one.
- Throughput: one result per cycle with out_ready held 1; back-to-back inputs produce back-to-back outputs with no bubbles.
- Output hold: out_sum and out_cout are held stable while out_valid=1 and out_ready=0.
- Wrap-around: sum is modulo 2^WIDTH; overflow is reported only via out_cout.
- Reset mid-operation: all in-flight results are discarded; no output is produced for them after reset release.
- Degenerate case: with STAGES=1 (CHUNK=WIDTH) the block becomes a single registered adder with latency 1.
- Bubbles: valid=0 slots carry don't-care data; out_sum is not required to change on bubbles.

Optional Feature:
- Macro PIPE_ADDER_OVF_EN.
- When defined: adds an output port out_ovf (1 bit), aligned and stalled with out_sum. out_ovf is the two's-complement overflow, computed as (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]). It resets to 0.
- When undefined: the port does not exist and no extra registers are built; all other behaviour is identical.

Test Plan (WIDTH=16, CHUNK=4, STAGES=4):
- Reset then idle -> out_valid=0, out_sum=0x0000, out_cout=0, in_ready=1.
- Single add a=0x00FF, b=0x0001, cin=0 -> out_valid pulses exactly 4 cycles later with out_sum=0x0100, out_cout=0. This exercises carry crossing stage boundaries.
- a=0xFFFF, b=0x0000, cin=1 -> out_sum=0x0000, out_cout=1 (full ripple through all stages). With PIPE_ADDER_OVF_EN: out_ovf=0. For a=0x7FFF, b=0x0001: out_ovf=1, out_sum=0x8000.
- Stream 8 back-to-back random pairs with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching a+b+cin.
- Stream with out_ready held 0 for 3 cycles mid-burst -> in_ready=0 during the stall, out_sum is held, and no result is lost or duplicated.
- Assert rst_n low with 3 results in flight -> no out_valid after release until new inputs are accepted.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: a WIDTH-bit ripple-carry adder. The add is split into CHUNK-bit slices, one slice per
// pipeline stage, with valid/ready handshakes on both sides. Define PIPE_ADDER_OVF_EN to add out_ovf.
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef PIPE_ADDER_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_cout
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             stall_s;
    logic             vld_r [STAGES];
    logic             c_r   [STAGES];
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] b_r   [STAGES];
    logic [WIDTH-1:0] sum_r [STAGES];
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf_r;
`endif

    // A single global stall freezes every stage while the output is held.
    assign stall_s   = out_valid & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = vld_r[STAGES-1];
    assign out_sum   = sum_r[STAGES-1];
    assign out_cout  = c_r[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src_s;
        logic [WIDTH-1:0] b_src_s;
        logic [WIDTH-1:0] sum_src_s;
        logic [WIDTH-1:0] sum_nxt_s;
        logic             cin_src_s;
        logic             vld_src_s;
        logic [CHUNK:0]   slice_s;

        if (k == 0) begin : g_head
            assign a_src_s   = in_a;
            assign b_src_s   = in_b;
            assign sum_src_s = {WIDTH{1'b0}};
            assign cin_src_s = in_cin;
            assign vld_src_s = in_valid;
        end else begin : g_body
            assign a_src_s   = a_r[k-1];
            assign b_src_s   = b_r[k-1];
            assign sum_src_s = sum_r[k-1];
            assign cin_src_s = c_r[k-1];
            assign vld_src_s = vld_r[k-1];
        end

        // Slice k of the add; lower slices are already final and pass straight through.
        always_comb begin
            slice_s = {1'b0, a_src_s[k*CHUNK +: CHUNK]}
                    + {1'b0, b_src_s[k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, cin_src_s};
            sum_nxt_s = sum_src_s;
            sum_nxt_s[k*CHUNK +: CHUNK] = slice_s[CHUNK-1:0];
        end

        // Stage register: holds on stall, otherwise loads operands, partial sum and slice carry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r[k] <= 1'b0;
                c_r[k]   <= 1'b0;
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
            end else if (!stall_s) begin
                vld_r[k] <= vld_src_s;
                c_r[k]   <= slice_s[CHUNK];
                a_r[k]   <= a_src_s;
                b_r[k]   <= b_src_s;
                sum_r[k] <= sum_nxt_s;
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // Signed overflow: the operands agree in sign but the result does not.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (!stall_s) begin
                    ovf_r <= (a_src_s[WIDTH-1] == b_src_s[WIDTH-1]) &
                             (sum_nxt_s[WIDTH-1] != a_src_s[WIDTH-1]);
                end
            end
        end
`endif
    end

`ifdef PIPE_ADDER_OVF_EN
    assign out_ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, CHUNK=4). A queue-based model predicts every output
// cycle from a+b+cin, the fixed latency and the stall rule.
module tb_pipe_adder;
    localparam int W = 16;
    localparam int C = 4;
    localparam int S = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef PIPE_ADDER_OVF_EN
    logic         out_ovf;
`endif

    int tests = 0;
    int fails = 0;
    int received = 0;
    int run_len = 0;
    int max_run = 0;
    bit done_flag;
    logic mv;
    logic ms;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum),
`ifdef PIPE_ADDER_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_cout(out_cout)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           wait_c;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        int   ua;
        int   sa;
        ua = int'(a) + int'(b) + int'(cin);
        sa = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.sum    = W'(ua % 65536);
        e.cout   = (ua >= 65536);
        e.ovf    = (sa > 32767) || (sa < -32768);
        e.wait_c = S - 1;
        return e;
    endfunction

    // Model and compare: one slot per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            run_len = 0;
        end else begin
            mv = (q.size() > 0) && (q[0].wait_c == 0);
            ms = mv && !out_ready;
            check("out_valid", 32'(out_valid), 32'(mv));
            check("in_ready", 32'(in_ready), 32'(!ms));
            if (mv) begin
                check("out_sum", 32'(out_sum), 32'(q[0].sum));
                check("out_cout", 32'(out_cout), 32'(q[0].cout));
`ifdef PIPE_ADDER_OVF_EN
                check("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
`endif
            end
            if (out_valid) run_len++; else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (mv && out_ready) begin
                void'(q.pop_front());
                received++;
            end
            if (!ms) begin
                foreach (q[i]) if (q[i].wait_c > 0) q[i].wait_c--;
                if (in_valid) q.push_back(model(in_a, in_b, in_cin));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input logic eo, input string name);
        int n;
        send(a, b, cin);
        n = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (out_valid) begin
                n = t;
                break;
            end
        end
        check({name, "_latency"}, 32'(n), 32'(S));
        check({name, "_sum"}, 32'(out_sum), 32'(es));
        check({name, "_cout"}, 32'(out_cout), 32'(ec));
`ifdef PIPE_ADDER_OVF_EN
        check({name, "_ovf"}, 32'(out_ovf), 32'(eo));
`else
        if (eo === 1'bx) check({name, "_ovf_arg"}, 32'(eo), 32'd0);
`endif
        @(negedge clk);
        check({name, "_pulse"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n, input int stall_at);
        fork
            begin
                for (int i = 0; i < n; i++) send(W'($urandom), W'($urandom), 1'($urandom));
            end
            begin
                if (stall_at >= 0) begin
                    repeat (stall_at) @(posedge clk);
                    #1 out_ready = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            end
        join
    endtask

    task automatic stream_rand(input int n);
        done_flag = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check({name, "_drain"}, 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int seen;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        out_ready = 1'b1; rst_n = 1'b0; done_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'h0000);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        single(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "carry_cross");
        single(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "full_ripple");
        single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        single(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_wrap");

        base = received; max_run = 0;
        stream(8, -1);
        drain("b2b");
        check("b2b_count", 32'(received - base), 32'd8);
        check("b2b_run", 32'(max_run), 32'd8);

        base = received;
        stream(12, 6);
        drain("stall");
        check("stall_count", 32'(received - base), 32'd12);

        base = received;
        stream_rand(40);
        drain("rand");
        check("rand_count", 32'(received - base), 32'd40);

        send(16'h1234, 16'h1111, 1'b0);
        send(16'h2222, 16'h3333, 1'b1);
        send(16'hABCD, 16'h0F0F, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_low", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        @(posedge clk); #1;
        single(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
